mem_access_unit: RTL and testbench

Multi-cycle data-memory access unit between the datapath's ALU address/store-data outputs and a variable-latency word-wide data SRAM. Accepts one load/store request at a time and generates byte enables and store-lane alignment. Returns load data sign/zero-extended or rotated (LWRR) for GRF write-back. Holds a stall to the datapath while the access is outstanding.

---
 rtl/mau_pkg.sv | 30 +++
 rtl/mem_access_unit_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types for the data-memory access unit: request encodings, FSM states
// and the alignment rule.
package mau_pkg;

  localparam int NUM_LANES = 4;

  // Bit 3 of the encoding marks a store.
  typedef enum logic [3:0] {
    LW   = 4'd0,
    LH   = 4'd1,
    LHU  = 4'd2,
    LB   = 4'd3,
    LBU  = 4'd4,
    LWRR = 4'd5,
    SW   = 4'd8,
    SH   = 4'd9,
    SB   = 4'd10
  } req_type_e;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  function automatic logic misaligned(input logic [3:0] t, input logic [1:0] off);
    case (t)
      LW, SW:      return off != 2'b00;
      LH, LHU, SH: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load result formatting: picks the addressed byte/half and extends it, or
// rotates the whole word for LWRR.
module load_align
  import mau_pkg::*;
(
  input  logic [3:0]  req_type,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [63:0] word_x2;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    // Rotate right by 8*offset via a doubled word; offset 0 leaves it unchanged.
    word_x2  = {word, word} >> {offset, 3'b000};
    case (req_type)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'd0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'd0, half_sel};
      LWRR:    data = word_x2[31:0];
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the datapath and a
// variable-latency word SRAM; stalls the datapath until the access retires.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state, state_nxt;
  logic [3:0]  type_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;
  logic [CW-1:0] cnt, cnt_inc;
  logic [NUM_LANES-1:0] be;
  logic [31:0] wdata_lane, align_data;
  logic        issue, done;

  assign cnt_inc = cnt + CW'(1);
  assign issue   = (state == S_ISSUE);
  assign done    = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = misaligned(req_type, req_addr[1:0]) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack || cnt_inc == CW'(TIMEOUT)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (req_valid) begin
          type_q  <= req_type;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= misaligned(req_type, req_addr[1:0]);
          cnt     <= '0;
        end
        S_WAIT: if (mem_ack) rdata_q <= mem_rdata;
                else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CW'(TIMEOUT)) err_q <= 1'b1;
                end
        default: ;
      endcase
    end
  end

  // Byte enables and lane replication so the SRAM can write any lane directly.
  always_comb begin
    be         = '1;
    wdata_lane = wdata_q;
    case (type_q)
      LH, LHU:     be = addr_q[1] ? 4'b1100 : 4'b0011;
      SH: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      LB, LBU:     be = 4'(4'b0001 << addr_q[1:0]);
      SB: begin
        be         = 4'(4'b0001 << addr_q[1:0]);
        wdata_lane = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  load_align u_align (
    .req_type (type_q),
    .offset   (addr_q[1:0]),
    .word     (rdata_q),
    .data     (align_data)
  );

  assign req_ready  = (state == S_IDLE);
  assign stall      = (req_ready & req_valid) | issue | (state == S_WAIT);
  assign mem_en     = issue;
  assign mem_we     = issue & type_q[3];
  assign mem_be     = issue ? be : '0;
  assign mem_addr   = issue ? addr_q[31:2] : '0;
  assign mem_wdata  = issue ? wdata_lane : '0;
  assign resp_valid = done;
  assign resp_err   = done & err_q;
  assign resp_data  = (done && !err_q && !type_q[3]) ? align_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized transactions
// checked against a byte-level reference model.
module tb_mem_access_unit;
  import mau_pkg::*;

  localparam int TO = 15;

  logic        clk = 0, reset = 0;
  logic        req_valid = 0, req_ready;
  logic [3:0]  req_type = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_data;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 0;

  int tests = 0, fails = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    int          stall_n;
    int          en_n;
    int          busy_ready;
    logic [3:0]  be;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } obs_t;

  // ---------------- reference model (byte-lane view) ----------------
  function automatic int sz(input logic [3:0] t);
    case (t)
      LW, SW, LWRR: return 4;
      LH, LHU, SH:  return 2;
      default:      return 1;
    endcase
  endfunction

  function automatic logic model_mis(input logic [3:0] t, input logic [31:0] a);
    if (t == LWRR) return 1'b0;
    return (a % sz(t)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [7:0] b[4];
    logic [31:0] r;
    int k, hb;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    k  = int'(a[1:0]);
    hb = a[1] ? 2 : 0;
    r  = w;
    case (t)
      LB:   r = {{24{b[k][7]}}, b[k]};
      LBU:  r = {24'd0, b[k]};
      LH:   r = {{16{b[hb+1][7]}}, b[hb+1], b[hb]};
      LHU:  r = {16'd0, b[hb+1], b[hb]};
      LWRR: for (int i = 0; i < 4; i++) r[8*i +: 8] = b[(i + k) % 4];
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] t, input logic [31:0] a);
    logic [3:0] be;
    int base;
    base = (t == LWRR) ? 0 : int'(a[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz(t));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] t, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(t)) +: 8];
    return r;
  endfunction

  // ---------------- stimulus driver: one transaction, records observations ----------------
  // Entered and left 1 time unit after a rising edge with the unit idle.
  // lat = cycles from mem_en to mem_ack; 0 = never acknowledge.
  task automatic run_txn(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int lat, output obs_t o);
    int en_c;
    logic got;
    o = '{default: 0};
    o.lat = -1;
    en_c = -1;
    got = 1'b0;
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
    for (int c = 0; c < 60 && !got; c++) begin
      mem_ack   = (lat > 0 && en_c >= 0 && c == en_c + lat);
      mem_rdata = mem_ack ? rd : $urandom;
      #2;
      if (stall) o.stall_n++;
      if (c > 0 && req_ready) o.busy_ready++;
      if (mem_en) begin
        o.en_n++; en_c = c;
        o.be = mem_be; o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
      end
      if (resp_valid) begin
        got = 1'b1; o.lat = c; o.data = resp_data; o.err = resp_err;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    tests++;
    if ({req_ready, resp_valid, resp_err, stall, mem_en, mem_we} !== 6'b100000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 100000",
                        {req_ready, resp_valid, resp_err, stall, mem_en, mem_we});
    end
    tests++;
    if ({resp_data, mem_be, mem_addr, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_data got %h %h %h %h exp all zero",
                        resp_data, mem_be, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_lw;
    obs_t o;
    run_txn(LW, 32'h10, 32'h0, 32'h11223344, 1, o);
    tests++; if (o.lat !== 3) begin fails++; $display("FAIL lw_latency got %0d exp 3", o.lat); end
    tests++; if (o.data !== 32'h11223344) begin fails++; $display("FAIL lw_data got %h exp 11223344", o.data); end
    tests++; if (o.be !== 4'b1111 || o.we !== 1'b0 || o.addr !== 30'h4) begin
      fails++; $display("FAIL lw_bus got be=%b we=%b addr=%h exp be=1111 we=0 addr=4", o.be, o.we, o.addr);
    end
    tests++; if (o.stall_n !== 3) begin fails++; $display("FAIL lw_stall got %0d exp 3", o.stall_n); end
    tests++; if (o.err !== 1'b0 || o.en_n !== 1 || o.busy_ready !== 0) begin
      fails++; $display("FAIL lw_misc got err=%b en=%0d busy_ready=%0d exp 0 1 0", o.err, o.en_n, o.busy_ready);
    end
  endtask

  task automatic test_lwrr;
    obs_t o;
    logic [31:0] addrs[3] = '{32'h13, 32'h11, 32'h10};
    logic [31:0] exps[3]  = '{32'h22334411, 32'h44112233, 32'h11223344};
    for (int i = 0; i < 3; i++) begin
      run_txn(LWRR, addrs[i], 32'h0, 32'h11223344, 2, o);
      tests++;
      if (o.data !== exps[i] || o.be !== 4'b1111 || o.err !== 1'b0) begin
        fails++; $display("FAIL lwrr_%0h got data=%h be=%b err=%b exp %h 1111 0",
                          addrs[i], o.data, o.be, o.err, exps[i]);
      end
    end
  endtask

  task automatic test_subword;
    obs_t o;
    logic [3:0]  ts[3]   = '{LB, LBU, LH};
    logic [31:0] exps[3] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899};
    logic [3:0]  bes[3]  = '{4'b0100, 4'b0100, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      run_txn(ts[i], 32'h12, 32'h0, 32'h8899AABB, 1, o);
      tests++;
      if (o.data !== exps[i] || o.be !== bes[i]) begin
        fails++; $display("FAIL subword_t%0d got data=%h be=%b exp %h %b",
                          ts[i], o.data, o.be, exps[i], bes[i]);
      end
    end
  endtask

  task automatic test_store;
    obs_t o;
    run_txn(SB, 32'h7, 32'h000000A5, 32'hDEADBEEF, 1, o);
    tests++; if (o.be !== 4'b1000 || o.we !== 1'b1 || o.wdata !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL sb_bus got be=%b we=%b wdata=%h exp 1000 1 a5a5a5a5", o.be, o.we, o.wdata);
    end
    tests++; if (o.data !== 32'h0 || o.err !== 1'b0 || o.lat !== 3) begin
      fails++; $display("FAIL sb_resp got data=%h err=%b lat=%0d exp 0 0 3", o.data, o.err, o.lat);
    end
    run_txn(SH, 32'h22, 32'h1234BEEF, 32'h0, 1, o);
    tests++; if (o.be !== 4'b1100 || o.wdata !== 32'hBEEFBEEF) begin
      fails++; $display("FAIL sh_bus got be=%b wdata=%h exp 1100 beefbeef", o.be, o.wdata);
    end
  endtask

  task automatic test_misaligned;
    obs_t o;
    logic [3:0]  ts[3] = '{LW, SH, LHU};
    logic [31:0] as[3] = '{32'h2, 32'h5, 32'h33};
    for (int i = 0; i < 3; i++) begin
      run_txn(ts[i], as[i], 32'hFFFFFFFF, 32'h12345678, 1, o);
      tests++;
      if (o.lat !== 1 || o.err !== 1'b1 || o.en_n !== 0 || o.data !== 32'h0 || o.stall_n !== 1) begin
        fails++; $display("FAIL misalign_%0d got lat=%0d err=%b en=%0d data=%h stall=%0d exp 1 1 0 0 1",
                          i, o.lat, o.err, o.en_n, o.data, o.stall_n);
      end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    int bad;
    run_txn(LW, 32'h40, 32'h0, 32'h0, 0, o);
    tests++; if (o.lat !== TO + 2 || o.err !== 1'b1 || o.data !== 32'h0) begin
      fails++; $display("FAIL timeout got lat=%0d err=%b data=%h exp %0d 1 0", o.lat, o.err, o.data, TO + 2);
    end
    bad = 0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      #2;
      if (resp_valid || mem_en || !req_ready) bad++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stray_ack got %0d bad cycles exp 0", bad); end
    // Ack on the last permitted WAIT cycle still completes cleanly.
    run_txn(LBU, 32'h41, 32'h0, 32'h0000AB00, TO, o);
    tests++; if (o.lat !== TO + 2 || o.err !== 1'b0 || o.data !== 32'hAB) begin
      fails++; $display("FAIL ack_at_limit got lat=%0d err=%b data=%h exp %0d 0 ab", o.lat, o.err, o.data, TO + 2);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int bad;
    req_valid = 1'b1; req_type = SW; req_addr = 32'h80; req_wdata = 32'h55AA55AA;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({req_ready, resp_valid, resp_err, stall, mem_en, mem_we} !== 6'b100000 ||
        {resp_data, mem_be, mem_addr, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_mid got ready=%b rv=%b err=%b stall=%b en=%b we=%b be=%b addr=%h exp reset values",
                        req_ready, resp_valid, resp_err, stall, mem_en, mem_we, mem_be, mem_addr);
    end
    @(posedge clk); #1 reset = 1'b1;
    bad = 0;
    mem_ack = 1'b1; mem_rdata = 32'h01020304;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (resp_valid || mem_en || stall) bad++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL reset_late_ack got %0d bad cycles exp 0", bad); end
    run_txn(LH, 32'h86, 32'h0, 32'h7FFE0000, 2, o);
    tests++; if (o.lat !== 4 || o.data !== 32'h00007FFE || o.err !== 1'b0) begin
      fails++; $display("FAIL post_reset got lat=%0d data=%h err=%b exp 4 00007ffe 0", o.lat, o.data, o.err);
    end
  endtask

  task automatic test_back_to_back;
    int en_q[$], rv_q[$];
    int en_last;
    int exp_en[3] = '{1, 5, 9};
    int exp_rv[3] = '{3, 7, 11};
    logic ok;
    en_last = -10;
    req_type = LW; req_addr = 32'h20; req_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 9);
      mem_ack   = (c == en_last + 1);
      mem_rdata = 32'h0BADF00D;
      #2;
      if (mem_en) begin en_q.push_back(c); en_last = c; end
      if (resp_valid) rv_q.push_back(c);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    ok = (en_q.size() == 3) && (rv_q.size() == 3);
    if (ok) for (int i = 0; i < 3; i++) ok &= (en_q[i] == exp_en[i]) && (rv_q[i] == exp_rv[i]);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL back_to_back got en=%p rv=%p exp en=1,5,9 rv=3,7,11", en_q, rv_q);
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic [3:0] types[9] = '{LW, LH, LHU, LB, LBU, LWRR, SW, SH, SB};
    logic [3:0]  t;
    logic [31:0] a, wd, rd, exp_d;
    logic mis, st;
    int lat, exp_lat;
    for (int n = 0; n < 40; n++) begin
      t = types[$urandom_range(0, 8)];
      a = $urandom; wd = $urandom; rd = $urandom;
      lat = $urandom_range(1, 4);
      mis = model_mis(t, a);
      st  = t[3];
      exp_lat = mis ? 1 : 2 + lat;
      exp_d   = (mis || st) ? 32'h0 : model_load(t, a, rd);
      run_txn(t, a, wd, rd, lat, o);
      tests++;
      if (o.lat !== exp_lat || o.err !== mis || o.data !== exp_d || o.stall_n !== exp_lat) begin
        fails++; $display("FAIL rand_resp t=%0d a=%h got lat=%0d err=%b data=%h stall=%0d exp %0d %b %h %0d",
                          t, a, o.lat, o.err, o.data, o.stall_n, exp_lat, mis, exp_d, exp_lat);
      end
      tests++;
      if (o.en_n !== (mis ? 0 : 1) ||
          (!mis && (o.be !== model_be(t, a) || o.we !== st || o.addr !== a[31:2])) ||
          (!mis && st && o.wdata !== model_wdata(t, wd))) begin
        fails++; $display("FAIL rand_bus t=%0d a=%h got en=%0d be=%b we=%b addr=%h wdata=%h exp be=%b wdata=%h",
                          t, a, o.en_n, o.be, o.we, o.addr, o.wdata, model_be(t, a), model_wdata(t, wd));
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lwrr;
    test_subword;
    test_store;
    test_misaligned;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
